// File: rtl/dpram_port_sequencer.sv
// Sequences single read/write transactions from an edge-triggered initiator
// onto a dual-port RAM with a fixed read latency of RD_LAT clocks.
module dpram_port_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              ar,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DIn,
  input  logic [DATA_W-1:0] Q,
  output logic [DATA_W-1:0] Data,
  output logic [ADDR_W-1:0] Wr_A,
  output logic [ADDR_W-1:0] Rd_A,
  output logic              WE,
  output logic [DATA_W-1:0] DOut,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t              state_q, state_d;
  logic                rd_dly_q, rd_dly_d;
  logic                wr_dly_q, wr_dly_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_a_q, wr_a_d;
  logic [ADDR_W-1:0]   rd_a_q, rd_a_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                err_q, err_d;
  logic                rd_edge, wr_edge;

  always_comb begin
    state_d  = state_q;
    rd_dly_d = RD;
    wr_dly_d = WR;
    cnt_d    = cnt_q;
    wr_a_d   = wr_a_q;
    rd_a_d   = rd_a_q;
    data_d   = data_q;
    dout_d   = dout_q;
    err_d    = 1'b0;
    rd_edge  = RD & ~rd_dly_q;
    wr_edge  = WR & ~wr_dly_q;

    case (state_q)
      IDLE: begin
        if (rd_edge && wr_edge) begin
          err_d = 1'b1;
        end else if (wr_edge) begin
          wr_a_d  = A;
          data_d  = DIn;
          state_d = WRITE;
        end else if (rd_edge) begin
          rd_a_d  = A;
          cnt_d   = LAT;
          state_d = READ_WAIT;
        end
      end
      WRITE: state_d = DONE;
      READ_WAIT: begin
        // Q is sampled on the edge where the countdown expires.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          dout_d  = Q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge-detect copies reset high so a request held through reset is not an edge.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q  <= IDLE;
      rd_dly_q <= 1'b1;
      wr_dly_q <= 1'b1;
      cnt_q    <= 2'd0;
      wr_a_q   <= '0;
      rd_a_q   <= '0;
      data_q   <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_dly_q <= rd_dly_d;
      wr_dly_q <= wr_dly_d;
      cnt_q    <= cnt_d;
      wr_a_q   <= wr_a_d;
      rd_a_q   <= rd_a_d;
      data_q   <= data_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  assign WE   = (state_q == WRITE);
  assign Done = (state_q == DONE);
  assign Busy = (state_q != IDLE);
  assign Err  = err_q;
  assign Wr_A = wr_a_q;
  assign Rd_A = rd_a_q;
  assign Data = data_q;
  assign DOut = dout_q;

endmodule

// File: doc/dpram_port_sequencer.md
DPRAM_PORT_SEQUENCER -- requirements
Module: dpram_port_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the data width.
REQ-003 The block SHALL have parameter RD_LAT, default 2, giving the DPRAM read latency in clocks (legal range 1..3).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port ar, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port RD, input, 1, read request from the initiator; rising edge qualifies.
REQ-007 The block SHALL have port WR, input, 1, write request from the initiator; rising edge qualifies.
REQ-008 The block SHALL have port A, input, ADDR_W, request address.
REQ-009 The block SHALL have port DIn, input, DATA_W, write data.
REQ-010 The block SHALL have port Q, input, DATA_W, DPRAM read-data port.
REQ-011 The block SHALL have port Data, output, DATA_W, DPRAM write data.
REQ-012 The block SHALL have port Wr_A, output, ADDR_W, DPRAM write address.
REQ-013 The block SHALL have port Rd_A, output, ADDR_W, DPRAM read address.
REQ-014 The block SHALL have port WE, output, 1, DPRAM write enable.
REQ-015 The block SHALL have port DOut, output, DATA_W, registered read result.
REQ-016 The block SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-017 The block SHALL have port Busy, output, 1, high whenever state is not IDLE.
REQ-018 The block SHALL have port Err, output, 1, one-cycle pulse for a rejected request.

Function
REQ-019 The block SHALL detect requests as a rising edge: a request is RD (or WR) high while its delayed copy is low, so a held level yields exactly one operation.
REQ-020 The FSM SHALL have the states IDLE, WRITE, READ_WAIT and DONE.
REQ-021 The block SHALL accept requests only in IDLE; request edges arriving in any other state SHALL be dropped, with no queuing and no Err.
REQ-022 Simultaneous RD and WR edges sampled in IDLE SHALL start no operation, SHALL pulse Err for exactly one cycle, and the FSM SHALL stay in IDLE.
REQ-023 A write edge sampled at edge n SHALL register A and DIn and move the FSM to WRITE.
REQ-024 During cycle n+1 the block SHALL drive WE=1, Wr_A equal to the captured A, and Data equal to the captured DIn, for exactly one cycle.
REQ-025 After the write cycle the FSM SHALL go to DONE; Done SHALL be high during cycle n+2, after which the FSM returns to IDLE.
REQ-026 A read edge sampled at edge n SHALL register A onto Rd_A, move the FSM to READ_WAIT, and load a latency counter with RD_LAT.
REQ-027 The latency counter SHALL decrement each cycle in READ_WAIT; at the edge where it reaches zero, Q SHALL be loaded into DOut and the FSM SHALL go to DONE.
REQ-028 Read Done SHALL be high during cycle n+1+RD_LAT, with DOut already valid in that same cycle.
REQ-029 DOut SHALL hold its value until the next completed read; writes SHALL NOT alter it.
REQ-030 Wr_A, Data and Rd_A SHALL hold their last values when idle.
REQ-031 WE SHALL be high only in WRITE.
REQ-032 A write followed by a read of the same address SHALL return the new data, because the write commits before its Done.
REQ-033 Addresses SHALL be used unmodified: no wrap-around logic and no arithmetic on them.

Reset
REQ-034 While ar=0, all outputs SHALL be 0, the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-035 While ar=0, both edge-detect registers SHALL be 1, so RD or WR held high through reset release starts no operation.
REQ-036 Reset asserted mid-operation SHALL abort the operation immediately: WE drops asynchronously, no Done is issued, and DOut clears.

Verification
REQ-037 The bench SHALL check: WR edge with A=0x005, DIn=0xBEEF -> WE=1 for one cycle with Wr_A=0x005 and Data=0xBEEF; Done one cycle later; Busy high for exactly 2 cycles.
REQ-038 The bench SHALL check: following RD edge with A=0x005, RD_LAT=2 -> Rd_A=0x005; Done exactly 3 cycles after the sampling edge with DOut=0xBEEF.
REQ-039 The bench SHALL check: RD and WR rise on the same edge -> Err pulses for 1 cycle; no WE, no Done; DOut unchanged.
REQ-040 The bench SHALL check: WR edge arriving while READ_WAIT -> ignored; only the read's Done; no WE pulse; and RD held high for 20 cycles -> exactly one Done.
REQ-041 The bench SHALL check: ar pulled low during WRITE -> WE=0, Done=0, DOut=0 at once; after release with RD held high -> no operation until RD toggles.
REQ-042 The bench SHALL check: address boundaries 0x000 and 0x3FF written with 0x0001 and 0xFFFF and read back -> exact values, no aliasing between the two.
